xor_stream_cipher: RTL and testbench

//   Parametrised successor of the single-byte XOR cipher: encrypts/decrypts a message of
//   1..MAX_LEN words against a multi-word key, word index i using key segment i mod NSEG.

---
 rtl/xor_stream_cipher.sv | 203 ++++++++++++++++++++
 tb/tb_xor_stream_cipher.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_stream_cipher.sv
// Streaming multi-word-key XOR cipher with optional chained mode and valid/ready on both sides.
// One word in per cycle, result out one cycle later; key segment i mod NSEG applies to word i.
module xor_stream_cipher #(
    parameter int DATA_W  = 8,
    parameter int KEY_W   = 32,
    parameter int MAX_LEN = 16,
    localparam int NSEG   = KEY_W / DATA_W,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KEY_W-1:0]  key,
    input  logic [LEN_W-1:0]  len,
    input  logic              chain,
    input  logic              decrypt,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int SEG_W = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
    localparam logic [SEG_W-1:0] LAST_SEG_C = SEG_W'(NSEG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [KEY_W-1:0]    key_r;
    logic [LEN_W-1:0]    len_r;
    logic                chain_r;
    logic                decrypt_r;
    logic [DATA_W-1:0]   prev_r;
    logic [LEN_W-1:0]    in_cnt_r;
    logic [LEN_W-1:0]    out_cnt_r;
    logic [SEG_W-1:0]    seg_r;
    logic                out_valid_r;
    logic [DATA_W-1:0]   out_data_r;

    logic                start_acc_s;
    logic [LEN_W-1:0]    len_clamp_s;
    logic                in_ready_s;
    logic                in_xfer_s;
    logic                out_xfer_s;
    logic                last_out_s;
    logic [DATA_W-1:0]   key_seg_s;
    logic [DATA_W-1:0]   result_s;
    logic                busy_s;
    logic                done_s;

    // The chain term is the previous ciphertext in both directions, so one helper covers enc and dec.
    function automatic logic [DATA_W-1:0] cipher_word(
        input logic [DATA_W-1:0] data,
        input logic [DATA_W-1:0] kseg,
        input logic [DATA_W-1:0] prev,
        input logic              chained
    );
        if (chained) begin
            return data ^ kseg ^ prev;
        end else begin
            return data ^ kseg;
        end
    endfunction

    // Handshake qualifiers, length clamp and the per-word cipher result.
    always_comb begin
        start_acc_s = (state_r == S_IDLE) && start;
        if (len > MAX_LEN_C) begin
            len_clamp_s = MAX_LEN_C;
        end else begin
            len_clamp_s = len;
        end
        in_ready_s = (state_r == S_RUN) && (in_cnt_r < len_r) && (!out_valid_r || out_ready);
        in_xfer_s  = in_valid && in_ready_s;
        out_xfer_s = out_valid_r && out_ready;
        last_out_s = out_xfer_s && (out_cnt_r == (len_r - LEN_W'(1)));
        key_seg_s  = key_r[seg_r * DATA_W +: DATA_W];
        result_s   = cipher_word(in_data, key_seg_s, prev_r, chain_r);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if (len_clamp_s == LEN_W'(0)) begin
                        state_nxt_s = S_DONE;
                    end else begin
                        state_nxt_s = S_RUN;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_out_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
            S_RUN: begin
                busy_s = 1'b1;
                done_s = 1'b0;
            end
            S_DONE: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Message context, counters, chain register and the registered output word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_r       <= {KEY_W{1'b0}};
            len_r       <= {LEN_W{1'b0}};
            chain_r     <= 1'b0;
            decrypt_r   <= 1'b0;
            prev_r      <= {DATA_W{1'b0}};
            in_cnt_r    <= {LEN_W{1'b0}};
            out_cnt_r   <= {LEN_W{1'b0}};
            seg_r       <= {SEG_W{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
        end else if (start_acc_s) begin
            key_r       <= key;
            len_r       <= len_clamp_s;
            chain_r     <= chain;
            decrypt_r   <= decrypt;
            prev_r      <= {DATA_W{1'b0}};
            in_cnt_r    <= {LEN_W{1'b0}};
            out_cnt_r   <= {LEN_W{1'b0}};
            seg_r       <= {SEG_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            // A new input word overrides the clear from a same-cycle output transfer.
            if (in_xfer_s) begin
                out_data_r  <= result_s;
                out_valid_r <= 1'b1;
                in_cnt_r    <= in_cnt_r + LEN_W'(1);
                if (seg_r == LAST_SEG_C) begin
                    seg_r <= {SEG_W{1'b0}};
                end else begin
                    seg_r <= seg_r + SEG_W'(1);
                end
                if (chain_r) begin
                    prev_r <= decrypt_r ? in_data : result_s;
                end
            end else if (out_xfer_s) begin
                out_valid_r <= 1'b0;
            end
            if (out_xfer_s) begin
                out_cnt_r <= out_cnt_r + LEN_W'(1);
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_s;
    assign done      = done_s;

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Self-checking bench for xor_stream_cipher: table vectors, hand-written corner sequences,
// and randomized messages scored against a word-by-word reference model.
module tb_xor_stream_cipher;

    localparam int DW = 8;
    localparam int KW = 16;
    localparam int ML = 16;
    localparam int LW = 5;

    logic          clk;
    logic          rst;
    logic          start;
    logic [KW-1:0] key;
    logic [LW-1:0] len;
    logic          chain;
    logic          decrypt;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          busy;
    logic          done;

    xor_stream_cipher #(.DATA_W(DW), .KEY_W(KW), .MAX_LEN(ML)) dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .len(len), .chain(chain),
        .decrypt(decrypt), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          ch;
        logic          dec;
        logic [LW-1:0] ln;
        logic [KW-1:0] k;
        logic [DW-1:0] din[3];
        logic [DW-1:0] dout[3];
    } vec_t;

    vec_t          tbl[3];
    int            vectors = 0;
    int            errors  = 0;
    bit            sb_en   = 1'b0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] msg_a[ML];
    logic [DW-1:0] exp_a[ML];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: word i uses key byte (i mod 2); chain term is the previous ciphertext word.
    task automatic model(input logic ch, input logic dec, input int n, input logic [KW-1:0] k);
        logic [DW-1:0] prev;
        logic [DW-1:0] kb;
        logic [DW-1:0] r;
        prev = '0;
        for (int i = 0; i < n; i++) begin
            kb = DW'(k >> (DW * (i % (KW / DW))));
            r  = msg_a[i] ^ kb ^ (ch ? prev : 8'h00);
            exp_a[i] = r;
            if (ch) prev = dec ? msg_a[i] : r;
        end
    endtask

    // Scoreboard: an output transfer is committed on the coming rising edge.
    always @(negedge clk) begin
        if (sb_en && rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {24'h0, out_data}, 32'hFFFF_FFFF);
            end else begin
                chk("sb_out_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic do_start(input logic ch, input logic dec, input logic [LW-1:0] ln, input logic [KW-1:0] k);
        start = 1'b1; chain = ch; decrypt = dec; len = ln; key = k;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_msg(input logic ch, input logic dec, input logic [LW-1:0] ln,
                           input logic [KW-1:0] k, input bit rnd);
        int  n;
        int  idx;
        int  cyc;
        bit  fire;
        bit  got_done;
        n = (ln > LW'(ML)) ? ML : int'(ln);
        for (int i = 0; i < n; i++) exp_q.push_back(exp_a[i]);
        sb_en = 1'b1;
        do_start(ch, dec, ln, k);
        chk("busy_after_start", {31'h0, busy}, 32'h1);
        got_done = done;
        idx = 0;
        cyc = 0;
        while (!got_done && cyc < 500) begin
            in_valid  = (idx < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            in_data   = (idx < n) ? msg_a[idx] : DW'($urandom);
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (fire) begin
                chk("latency_valid", {31'h0, out_valid}, 32'h1);
                chk("latency_data", {24'h0, out_data}, {24'h0, exp_a[idx]});
                idx++;
            end
            if (done) got_done = 1'b1;
        end
        in_valid = 1'b0;
        chk("done_seen", {31'h0, got_done}, 32'h1);
        chk("words_accepted", idx, n);
        chk("queue_drained", exp_q.size(), 0);
        @(posedge clk); #1;
        chk("done_one_cycle", {31'h0, done}, 32'h0);
        chk("idle_busy", {31'h0, busy}, 32'h0);
        sb_en = 1'b0;
    endtask

    initial begin
        tbl[0] = '{ch: 1'b0, dec: 1'b0, ln: 5'd3, k: 16'hAA55,
                   din: '{8'hCC, 8'h3C, 8'h00}, dout: '{8'h99, 8'h96, 8'h55}};
        tbl[1] = '{ch: 1'b1, dec: 1'b0, ln: 5'd3, k: 16'hAA55,
                   din: '{8'hCC, 8'h3C, 8'h00}, dout: '{8'h99, 8'h0F, 8'h5A}};
        tbl[2] = '{ch: 1'b1, dec: 1'b1, ln: 5'd3, k: 16'hAA55,
                   din: '{8'h99, 8'h0F, 8'h5A}, dout: '{8'hCC, 8'h3C, 8'h00}};

        rst = 1'b0; start = 1'b0; key = '0; len = '0; chain = 1'b0; decrypt = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data", {24'h0, out_data}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 3; i++) begin
                msg_a[i] = tbl[v].din[i];
                exp_a[i] = tbl[v].dout[i];
            end
            run_msg(tbl[v].ch, tbl[v].dec, tbl[v].ln, tbl[v].k, 1'b0);
        end

        // Backpressure: output stalls for three cycles after the first word.
        do_start(1'b0, 1'b0, 5'd3, 16'hAA55);
        in_valid = 1'b1; in_data = 8'hCC; out_ready = 1'b1; #1;
        chk("bp_in_ready0", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        chk("bp_first", {24'h0, out_data}, 32'h99);
        in_data = 8'h3C; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_stall_ready", {31'h0, in_ready}, 32'h0);
            @(posedge clk); #1;
            chk("bp_hold_data", {24'h0, out_data}, 32'h99);
            chk("bp_hold_valid", {31'h0, out_valid}, 32'h1);
        end
        out_ready = 1'b1; #1;
        chk("bp_resume_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        chk("bp_second", {24'h0, out_data}, 32'h96);
        in_data = 8'h00;
        @(posedge clk); #1;
        chk("bp_third", {24'h0, out_data}, 32'h55);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_done", {31'h0, done}, 32'h1);
        chk("bp_out_cleared", {31'h0, out_valid}, 32'h0);
        @(posedge clk); #1;

        // len=0: straight to DONE, never ready for input.
        do_start(1'b0, 1'b0, 5'd0, 16'h1234);
        in_valid = 1'b1; in_data = 8'h77; #1;
        chk("len0_done", {31'h0, done}, 32'h1);
        chk("len0_in_ready", {31'h0, in_ready}, 32'h0);
        @(posedge clk); #1;
        chk("len0_busy_clear", {31'h0, busy}, 32'h0);
        chk("len0_no_output", {31'h0, out_valid}, 32'h0);
        in_valid = 1'b0;

        // A start while RUN must not relatch key or length.
        do_start(1'b0, 1'b0, 5'd2, 16'hAA55);
        do_start(1'b0, 1'b0, 5'd0, 16'h0000);
        chk("run_start_busy", {31'h0, busy}, 32'h1);
        chk("run_start_nodone", {31'h0, done}, 32'h0);
        in_valid = 1'b1; in_data = 8'h0F;
        @(posedge clk); #1;
        chk("run_start_w0", {24'h0, out_data}, 32'h5A);
        in_data = 8'hF0;
        @(posedge clk); #1;
        chk("run_start_w1", {24'h0, out_data}, 32'h5A);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("run_start_done", {31'h0, done}, 32'h1);
        @(posedge clk); #1;

        // Reset mid-message, then a fresh message must run cleanly.
        do_start(1'b0, 1'b0, 5'd4, 16'hAA55);
        in_valid = 1'b1; in_data = 8'h11;
        @(posedge clk); #1;
        in_data = 8'h22;
        @(posedge clk); #1;
        chk("mid_w1", {24'h0, out_data}, 32'h88);
        rst = 1'b0; in_valid = 1'b0; #1;
        chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_data", {24'h0, out_data}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_ready", {31'h0, in_ready}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            msg_a[i] = tbl[1].din[i];
            exp_a[i] = tbl[1].dout[i];
        end
        run_msg(1'b1, 1'b0, 5'd3, 16'hAA55, 1'b0);

        // Length above MAX_LEN clamps to 16 words.
        for (int i = 0; i < ML; i++) msg_a[i] = DW'($urandom);
        model(1'b0, 1'b0, ML, 16'h5AA5);
        run_msg(1'b0, 1'b0, 5'd31, 16'h5AA5, 1'b0);

        for (int t = 0; t < 30; t++) begin
            logic          rch;
            logic          rdec;
            logic [LW-1:0] rln;
            logic [KW-1:0] rk;
            int            rn;
            rch  = 1'($urandom);
            rdec = 1'($urandom);
            rln  = LW'($urandom_range(0, 20));
            rk   = KW'($urandom);
            rn   = (rln > LW'(ML)) ? ML : int'(rln);
            for (int i = 0; i < ML; i++) msg_a[i] = DW'($urandom);
            model(rch, rdec, rn, rk);
            run_msg(rch, rdec, rln, rk, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
